// File: rtl/bist_lfsr_misr.sv
// BIST datapath pair: Fibonacci LFSR pattern generator and serial-input MISR
// signature compactor, each with its own enable and synchronous clear.
module bist_lfsr_misr #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] LFSR_SEED = 16'hACE1,
    parameter logic [WIDTH-1:0] MISR_POLY = 16'h1021,
    parameter logic [WIDTH-1:0] MISR_SEED = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lfsr_en,
    input  logic             lfsr_clr,
    output logic             lfsr_out,
    output logic [WIDTH-1:0] lfsr_state,
    input  logic             misr_en,
    input  logic             misr_clr,
    input  logic             misr_in,
    output logic [WIDTH-1:0] misr_sig
);

    logic [WIDTH-1:0] lfsr_state_q, lfsr_state_d;
    logic [WIDTH-1:0] misr_sig_q, misr_sig_d;
    logic             misr_fb;

    // Tap mask bit i selects state bit WIDTH-1-i (mask is written MSB-first as a polynomial).
    function automatic logic lfsr_feedback(input logic [WIDTH-1:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LFSR_TAPS[i]) begin
                fb = fb ^ s[WIDTH-1-i];
            end
        end
        return fb;
    endfunction

    always_comb begin
        lfsr_state_d = lfsr_state_q;
        if (lfsr_clr) begin
            lfsr_state_d = LFSR_SEED;
        end else if (lfsr_en) begin
            // An all-zero register would never leave zero; reseed instead of shifting.
            if (lfsr_state_q == '0) begin
                lfsr_state_d = LFSR_SEED;
            end else begin
                lfsr_state_d = {lfsr_feedback(lfsr_state_q), lfsr_state_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        misr_fb    = misr_sig_q[WIDTH-1] ^ misr_in;
        misr_sig_d = misr_sig_q;
        if (misr_clr) begin
            misr_sig_d = MISR_SEED;
        end else if (misr_en) begin
            misr_sig_d = {misr_sig_q[WIDTH-2:0], 1'b0} ^ (misr_fb ? MISR_POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_state_q <= LFSR_SEED;
            misr_sig_q   <= MISR_SEED;
        end else begin
            lfsr_state_q <= lfsr_state_d;
            misr_sig_q   <= misr_sig_d;
        end
    end

    assign lfsr_state = lfsr_state_q;
    assign lfsr_out   = lfsr_state_q[0];
    assign misr_sig   = misr_sig_q;

endmodule

// File: tb/tb_bist_lfsr_misr.sv
// Directed bench for bist_lfsr_misr: vector table plus reset, period,
// fault-detection and mid-run async reset sequences.
module tb_bist_lfsr_misr;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic        lfsr_en, lfsr_clr, misr_en, misr_clr, misr_in;
    logic        lfsr_out;
    logic [15:0] lfsr_state, misr_sig;

    int checks;
    int failures;

    bist_lfsr_misr dut (
        .clk        (clk),
        .rst        (rst),
        .lfsr_en    (lfsr_en),
        .lfsr_clr   (lfsr_clr),
        .lfsr_out   (lfsr_out),
        .lfsr_state (lfsr_state),
        .misr_en    (misr_en),
        .misr_clr   (misr_clr),
        .misr_in    (misr_in),
        .misr_sig   (misr_sig)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic        le, lc, me, mc, mi;
        logic [15:0] exp_l;
        logic        exp_o;
        logic [15:0] exp_m;
    } vec_t;

    vec_t vecs[7];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    // Reference models written directly from the polynomial definitions.
    function automatic logic [15:0] m_lfsr(input logic [15:0] s);
        if (s == 16'h0) return 16'hACE1;
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] s, input logic b);
        logic [15:0] r;
        r = s << 1;
        if (s[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic drive(input logic le, input logic lc, input logic me, input logic mc, input logic mi);
        lfsr_en  = le;
        lfsr_clr = lc;
        misr_en  = me;
        misr_clr = mc;
        misr_in  = mi;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clears both halves, then compacts 2000 LFSR bits; flips bit flip_idx if >= 0.
    task automatic compact_run(input int flip_idx, output logic [15:0] sig,
                               output logic [15:0] model_sig, output logic [15:0] model_l);
        logic [15:0] ml, mm;
        logic        b;
        drive(1, 1, 1, 1, 0);
        tick();
        ml = 16'hACE1;
        mm = 16'h0000;
        for (int i = 0; i < 2000; i++) begin
            b = ml[0] ^ (i == flip_idx);
            drive(1, 0, 1, 0, b);
            mm = m_misr(mm, b);
            ml = m_lfsr(ml);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        sig       = misr_sig;
        model_sig = mm;
        model_l   = ml;
    endtask

    initial begin
        logic [15:0] held;
        logic        held_o;
        int          early;
        logic [15:0] sig1, sig2, sig3, msig, ml;

        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        clk_run  = 1'b0;
        rst      = 1'b1;
        drive(0, 0, 0, 0, 0);

        //              le lc me mc mi  exp_l     out   exp_m
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5670, 1'b0, 16'h1021};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hAB38, 1'b0, 16'h3063};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAB38, 1'b0, 16'h60C6};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAB38, 1'b0, 16'h60C6};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hACE1, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5670, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hACE1, 1'b1, 16'h1021};

        // Reset with the clock stopped
        #2 rst = 1'b0;
        #1;
        chk16("reset_lfsr_state", lfsr_state, 16'hACE1);
        chk1 ("reset_lfsr_out", lfsr_out, 1'b1);
        chk16("reset_misr_sig", misr_sig, 16'h0000);
        #2 rst = 1'b1;
        #1 clk_run = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].le, vecs[i].lc, vecs[i].me, vecs[i].mc, vecs[i].mi);
            tick();
            chk16($sformatf("vec%0d_lfsr_state", i), lfsr_state, vecs[i].exp_l);
            chk1 ($sformatf("vec%0d_lfsr_out", i), lfsr_out, vecs[i].exp_o);
            chk16($sformatf("vec%0d_misr_sig", i), misr_sig, vecs[i].exp_m);
        end

        // Hold for 10 cycles after stepping off the seed
        drive(1, 0, 0, 0, 1);
        tick();
        chk16("pre_hold_lfsr", lfsr_state, 16'h5670);
        held   = lfsr_state;
        held_o = lfsr_out;
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tick();
        chk16("hold_lfsr_state", lfsr_state, held);
        chk1 ("hold_lfsr_out", lfsr_out, held_o);
        chk16("hold_misr_sig", misr_sig, 16'h1021);

        // Full period from the seed
        drive(0, 1, 0, 0, 0);
        tick();
        chk16("period_start", lfsr_state, 16'hACE1);
        drive(1, 0, 0, 0, 0);
        early = 0;
        for (int i = 1; i < 65535; i++) begin
            tick();
            if (lfsr_state == 16'hACE1 || lfsr_state == 16'h0000) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL period_early_repeat got=%0d exp=0", early);
        end
        tick();
        chk16("period_return", lfsr_state, 16'hACE1);
        drive(0, 0, 0, 0, 0);

        // Fault detection: clean, single-bit error, clean rerun
        compact_run(-1, sig1, msig, ml);
        chk16("golden_sig_model", sig1, msig);
        chk16("golden_lfsr_model", lfsr_state, ml);
        compact_run(1000, sig2, msig, ml);
        chk16("faulty_sig_model", sig2, msig);
        checks++;
        if (sig2 === sig1) begin
            failures++;
            $display("FAIL fault_detect got=%h exp!=%h", sig2, sig1);
        end
        compact_run(-1, sig3, msig, ml);
        chk16("golden_rerun", sig3, sig1);

        // Async reset between edges while both halves step
        drive(1, 0, 1, 0, 1);
        tick();
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk16("midrst_lfsr_state", lfsr_state, 16'hACE1);
        chk1 ("midrst_lfsr_out", lfsr_out, 1'b1);
        chk16("midrst_misr_sig", misr_sig, 16'h0000);
        #1 rst = 1'b1;
        tick();
        chk16("resume_lfsr_state", lfsr_state, 16'h5670);
        chk16("resume_misr_sig", misr_sig, 16'h1021);
        drive(1, 0, 1, 0, 1);
        tick();
        chk16("resume2_lfsr_state", lfsr_state, 16'hAB38);
        chk16("resume2_misr_sig", misr_sig, 16'h3063);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
